// File: rtl/sseg_share_arbiter_if.sv
// Display-sharing bundle: two requesters' req/digit inputs plus the grant, done and digit/blank feed to the display mux.
// The master side is the requesters and display mux; the slave side is the arbiter.
interface sseg_share_arbiter_if;
   logic       req0;
   logic [7:0] data0;
   logic       req1;
   logic [7:0] data1;
   logic       gnt0;
   logic       gnt1;
   logic       done0;
   logic       done1;
   logic [3:0] hex0;
   logic [3:0] hex1;
   logic       blank;

   modport master (
      output req0, data0, req1, data1,
      input  gnt0, gnt1, done0, done1, hex0, hex1, blank
   );

   modport slave (
      input  req0, data0, req1, data1,
      output gnt0, gnt1, done0, done1, hex0, hex1, blank
   );
endinterface

// File: rtl/sseg_share_arbiter.sv
// Round-robin time-share of the 2-digit display; grant/digits registered one edge after req, each window fixed at HOLD_CYCLES, no preemption.
// Requesters are never stalled, only delayed to the next window boundary; SSEG_ARB_LIVE_EN makes the digits track the owner's data every cycle.
module sseg_share_arbiter #(
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic                clk,
   input  logic                reset,
   sseg_share_arbiter_if.slave bus
);

   localparam int            TW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic          ONE_CYCLE = (HOLD_CYCLES == 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic          last;
   logic          gnt0_q;
   logic          gnt1_q;
   logic          done0_q;
   logic          done1_q;
   logic [3:0]    hex0_q;
   logic [3:0]    hex1_q;
   logic          blank_q;

   logic          win_end;
   logic          arb_last;
   logic          pick0;
   logic          pick1;
   logic [TW-1:0] timer_inc;

   // At a window end the current owner counts as "last", so the other side wins a tie.
   always_comb begin
      win_end   = (state == IDLE) || (timer == LAST_TICK);
      timer_inc = timer + TICK_ONE;
      arb_last  = last;
      if (state == OWN0) begin
         arb_last = 1'b0;
      end else if (state == OWN1) begin
         arb_last = 1'b1;
      end
      pick0 = bus.req0 && (!bus.req1 || arb_last);
      pick1 = bus.req1 && !pick0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         last    <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         hex0_q  <= 4'h0;
         hex1_q  <= 4'h0;
         blank_q <= 1'b1;
      end else if (win_end) begin
         if (state != IDLE) begin
            last <= (state == OWN1);
         end
         timer   <= '0;
         gnt0_q  <= pick0;
         gnt1_q  <= pick1;
         // A one-cycle window is also its own last cycle.
         done0_q <= pick0 && ONE_CYCLE;
         done1_q <= pick1 && ONE_CYCLE;
         blank_q <= !(pick0 || pick1);
         if (pick0) begin
            state  <= OWN0;
            hex1_q <= bus.data0[7:4];
            hex0_q <= bus.data0[3:0];
         end else if (pick1) begin
            state  <= OWN1;
            hex1_q <= bus.data1[7:4];
            hex0_q <= bus.data1[3:0];
         end else begin
            state  <= IDLE;
         end
      end else begin
         timer   <= timer_inc;
         done0_q <= (state == OWN0) && (timer_inc == LAST_TICK);
         done1_q <= (state == OWN1) && (timer_inc == LAST_TICK);
`ifdef SSEG_ARB_LIVE_EN
         if (state == OWN0) begin
            hex1_q <= bus.data0[7:4];
            hex0_q <= bus.data0[3:0];
         end else begin
            hex1_q <= bus.data1[7:4];
            hex0_q <= bus.data1[3:0];
         end
`else
         hex1_q <= hex1_q;
         hex0_q <= hex0_q;
`endif
      end
   end

   assign bus.gnt0  = gnt0_q;
   assign bus.gnt1  = gnt1_q;
   assign bus.done0 = done0_q;
   assign bus.done1 = done1_q;
   assign bus.hex0  = hex0_q;
   assign bus.hex1  = hex1_q;
   assign bus.blank = blank_q;

endmodule

// File: tb/tb_sseg_share_arbiter.sv
// Directed vector table plus hand-written corner sequences for sseg_share_arbiter at HOLD_CYCLES=4.
module tb_sseg_share_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sseg_share_arbiter_if bus ();

   sseg_share_arbiter #(.HOLD_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        r0;
      logic [7:0]  d0;
      logic        r1;
      logic [7:0]  d1;
      logic [12:0] exp;   // {gnt0, gnt1, done0, done1, blank, hex1, hex0}
   } vec_t;

   vec_t tbl[$];

   function automatic logic [12:0] o(input logic g0, input logic g1, input logic dn0,
                                     input logic dn1, input logic bl, input logic [7:0] hx);
      return {g0, g1, dn0, dn1, bl, hx};
   endfunction

   function automatic vec_t v(input logic rst, input logic r0, input logic [7:0] d0,
                              input logic r1, input logic [7:0] d1, input logic [12:0] exp);
      vec_t t;
      t.rst = rst; t.r0 = r0; t.d0 = d0; t.r1 = r1; t.d1 = d1; t.exp = exp;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [12:0] exp);
      logic [12:0] act;
      act = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.blank, bus.hex1, bus.hex0};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got g0g1d0d1bl=%b hex=%h expected g0g1d0d1bl=%b hex=%h",
                  tag, act[12:8], act[7:0], exp[12:8], exp[7:0]);
      end
   endtask

   logic [7:0] mid_hex;

   initial begin
      checks = 0;
      errors = 0;
`ifdef SSEG_ARB_LIVE_EN
      mid_hex = 8'h45;
`else
      mid_hex = 8'h12;
`endif
      // Reset and idle
      tbl.push_back(v(1, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h00)));
      tbl.push_back(v(1, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h00)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h00)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h00)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h00)));
      // req0 held: window, then gapless fresh window with recaptured data
      tbl.push_back(v(0, 1, 8'h37, 0, 8'h00, o(1, 0, 0, 0, 0, 8'h37)));
      tbl.push_back(v(0, 1, 8'h37, 0, 8'h00, o(1, 0, 0, 0, 0, 8'h37)));
      tbl.push_back(v(0, 1, 8'h37, 0, 8'h00, o(1, 0, 0, 0, 0, 8'h37)));
      tbl.push_back(v(0, 1, 8'h37, 0, 8'h00, o(1, 0, 1, 0, 0, 8'h37)));
      tbl.push_back(v(0, 1, 8'h5A, 0, 8'h00, o(1, 0, 0, 0, 0, 8'h5A)));
      tbl.push_back(v(0, 0, 8'h5A, 0, 8'h00, o(1, 0, 0, 0, 0, 8'h5A)));
      tbl.push_back(v(0, 0, 8'h5A, 0, 8'h00, o(1, 0, 0, 0, 0, 8'h5A)));
      tbl.push_back(v(0, 0, 8'h5A, 0, 8'h00, o(1, 0, 1, 0, 0, 8'h5A)));
      tbl.push_back(v(0, 0, 8'h5A, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h5A)));
      tbl.push_back(v(0, 0, 8'h5A, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h5A)));
      // Reset, then both requesting: 0 wins first, alternation with no gap
      tbl.push_back(v(1, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h00)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(1, 0, 0, 0, 0, 8'h11)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(1, 0, 0, 0, 0, 8'h11)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(1, 0, 0, 0, 0, 8'h11)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(1, 0, 1, 0, 0, 8'h11)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(0, 1, 0, 0, 0, 8'h22)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(0, 1, 0, 0, 0, 8'h22)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(0, 1, 0, 0, 0, 8'h22)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(0, 1, 0, 1, 0, 8'h22)));
      tbl.push_back(v(0, 1, 8'h11, 1, 8'h22, o(1, 0, 0, 0, 0, 8'h11)));
      tbl.push_back(v(0, 0, 8'h11, 0, 8'h22, o(1, 0, 0, 0, 0, 8'h11)));
      tbl.push_back(v(0, 0, 8'h11, 0, 8'h22, o(1, 0, 0, 0, 0, 8'h11)));
      tbl.push_back(v(0, 0, 8'h11, 0, 8'h22, o(1, 0, 1, 0, 0, 8'h11)));
      tbl.push_back(v(0, 0, 8'h11, 0, 8'h22, o(0, 0, 0, 0, 1, 8'h11)));
      // Single-cycle req1 pulse still earns a full window
      tbl.push_back(v(0, 0, 8'h00, 1, 8'h9C, o(0, 1, 0, 0, 0, 8'h9C)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h9C, o(0, 1, 0, 0, 0, 8'h9C)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h9C, o(0, 1, 0, 0, 0, 8'h9C)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h9C, o(0, 1, 0, 1, 0, 8'h9C)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h9C, o(0, 0, 0, 0, 1, 8'h9C)));
      tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, o(0, 0, 0, 0, 1, 8'h9C)));

      reset = 1'b1; bus.req0 = 1'b0; bus.data0 = 8'h00; bus.req1 = 1'b0; bus.data1 = 8'h00;
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; bus.req0 = tbl[i].r0; bus.data0 = tbl[i].d0;
         bus.req1 = tbl[i].r1; bus.data1 = tbl[i].d1;
         tick();
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Data change mid-window: held capture vs. live follow
      bus.req0 = 1'b1; bus.data0 = 8'h12;
      tick(); check("cap_c1", o(1, 0, 0, 0, 0, 8'h12));
      bus.req0 = 1'b0;
      tick(); check("cap_c2", o(1, 0, 0, 0, 0, 8'h12));
      bus.data0 = 8'h45;
      tick(); check("cap_c3", o(1, 0, 0, 0, 0, mid_hex));
      tick(); check("cap_c4", o(1, 0, 1, 0, 0, mid_hex));
      tick(); check("cap_idle", o(0, 0, 0, 0, 1, mid_hex));

      // Reset in window cycle 2 aborts without a done pulse, then req1 alone
      bus.req0 = 1'b1; bus.data0 = 8'h66;
      tick(); check("rst_c1", o(1, 0, 0, 0, 0, 8'h66));
      reset = 1'b1;
      tick(); check("rst_abort", o(0, 0, 0, 0, 1, 8'h00));
      reset = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b1; bus.data1 = 8'h7E;
      tick(); check("rst_g1_c1", o(0, 1, 0, 0, 0, 8'h7E));
      bus.req1 = 1'b0;
      tick(); check("rst_g1_c2", o(0, 1, 0, 0, 0, 8'h7E));
      tick(); check("rst_g1_c3", o(0, 1, 0, 0, 0, 8'h7E));
      tick(); check("rst_g1_c4", o(0, 1, 0, 1, 0, 8'h7E));
      tick(); check("rst_idle", o(0, 0, 0, 0, 1, 8'h7E));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
